// File: rtl/ihex_pkg.sv
// Shared definitions for the Intel HEX receive path.
package ihex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_ADDR,
    ST_TYPE,
    ST_DATA,
    ST_CSUM,
    ST_CHECK,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] REC_DATA    = 8'h00;
  localparam logic [7:0] REC_EOF     = 8'h01;
  localparam logic [7:0] REC_ELA     = 8'h04;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

endpackage

// File: rtl/hex_char_decode.sv
// ASCII hex character to nibble; accepts 0-9, A-F and a-f.
module hex_char_decode (
  input  logic [7:0] ch,
  output logic       valid,
  output logic [3:0] nibble
);

  // Range-decode the character and subtract the matching ASCII base.
  always_comb begin
    valid  = 1'b0;
    nibble = '0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      valid  = 1'b1;
      nibble = 4'(ch - 8'h30);
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      valid  = 1'b1;
      nibble = 4'(ch - 8'h37);
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      valid  = 1'b1;
      nibble = 4'(ch - 8'h57);
    end
  end

endmodule

// File: rtl/ihex_record_parser.sv
// Intel HEX record parser: buffers a record's data bytes, verifies the
// checksum and type rules, then streams the bytes out with absolute addresses.
module ihex_record_parser
  import ihex_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rx_stb,
  input  logic [7:0]  i_rx_data,
  output logic        o_byte_valid,
  output logic [31:0] o_byte_addr,
  output logic [7:0]  o_byte_data,
  input  logic        i_byte_ready,
  output logic        o_done_stb,
  output logic        o_done_err,
  output logic        o_eof,
  output logic        o_busy
);

  localparam int unsigned CNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t           state;
  logic             phase;
  logic [3:0]       hi_nib;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       len;
  logic [7:0]       rtype;
  logic [7:0]       sum;
  logic [15:0]      addr16;
  logic [15:0]      ela;
  logic [7:0]       rec_buf [MAX_LEN];

  logic             ch_valid;
  logic [3:0]       ch_nib;
  logic [7:0]       byte_val;
  logic [7:0]       sum_next;
  logic             is_colon;
  logic             cnt_is_last;
  logic             check_ok;

  hex_char_decode u_dec (
    .ch     (i_rx_data),
    .valid  (ch_valid),
    .nibble (ch_nib)
  );

  assign byte_val    = {hi_nib, ch_nib};
  assign sum_next    = sum + byte_val;
  assign is_colon    = (i_rx_data == ASCII_COLON);
  assign cnt_is_last = (8'(cnt) == len - 8'd1);

  assign o_busy       = (state != ST_IDLE);
  assign o_byte_valid = (state == ST_DRAIN);
  assign o_byte_addr  = {ela, addr16 + 16'(cnt)};
  assign o_byte_data  = rec_buf[cnt];

  // Record acceptance: checksum must be zero and length must suit the type.
  always_comb begin
    check_ok = 1'b0;
    if (sum == 8'h00) begin
      case (rtype)
        REC_DATA:            check_ok = 1'b1;
        REC_EOF:             check_ok = (len == 8'd0);
        REC_ELA:             check_ok = (len == 8'd2);
        8'h02, 8'h03, 8'h05: check_ok = 1'b1;
        default:             check_ok = 1'b0;
      endcase
    end
  end

  // Record FSM: field parsing, buffering, verification and drain.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      phase      <= 1'b0;
      hi_nib     <= '0;
      cnt        <= '0;
      len        <= '0;
      rtype      <= '0;
      sum        <= '0;
      addr16     <= '0;
      ela        <= '0;
      o_done_stb <= 1'b0;
      o_done_err <= 1'b0;
      o_eof      <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) rec_buf[i] <= '0;
    end else begin
      o_done_stb <= 1'b0;
      o_done_err <= 1'b0;
      o_eof      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_stb && is_colon) begin
            state <= ST_LEN;
            phase <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        ST_LEN, ST_ADDR, ST_TYPE, ST_DATA, ST_CSUM: begin
          if (i_rx_stb) begin
            if (is_colon) begin
              // Abort this record and treat the colon as the start of a new one.
              o_done_stb <= 1'b1;
              o_done_err <= 1'b1;
              state      <= ST_LEN;
              phase      <= 1'b0;
              cnt        <= '0;
              sum        <= '0;
            end else if (!ch_valid) begin
              o_done_stb <= 1'b1;
              o_done_err <= 1'b1;
              state      <= ST_IDLE;
            end else if (!phase) begin
              hi_nib <= ch_nib;
              phase  <= 1'b1;
            end else begin
              phase <= 1'b0;
              sum   <= sum_next;
              case (state)
                ST_LEN: begin
                  len <= byte_val;
                  cnt <= '0;
                  if (byte_val > 8'(MAX_LEN)) begin
                    o_done_stb <= 1'b1;
                    o_done_err <= 1'b1;
                    state      <= ST_IDLE;
                  end else begin
                    state <= ST_ADDR;
                  end
                end
                ST_ADDR: begin
                  if (cnt == '0) begin
                    addr16[15:8] <= byte_val;
                    cnt          <= cnt + 1'b1;
                  end else begin
                    addr16[7:0] <= byte_val;
                    state       <= ST_TYPE;
                  end
                end
                ST_TYPE: begin
                  rtype <= byte_val;
                  cnt   <= '0;
                  state <= (len == 8'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                  rec_buf[cnt] <= byte_val;
                  if (cnt_is_last) state <= ST_CSUM;
                  else             cnt   <= cnt + 1'b1;
                end
                default: state <= ST_CHECK;
              endcase
            end
          end
        end
        ST_CHECK: begin
          if (!check_ok) begin
            o_done_stb <= 1'b1;
            o_done_err <= 1'b1;
            state      <= ST_IDLE;
          end else if (rtype == REC_DATA && len != 8'd0) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            o_done_stb <= 1'b1;
            o_eof      <= (rtype == REC_EOF);
            if (rtype == REC_ELA) ela <= {rec_buf[0], rec_buf[1]};
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (i_byte_ready) begin
            if (cnt_is_last) begin
              o_done_stb <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ihex_record_parser.sv
// Scoreboard bench for ihex_record_parser: stimulus pushes expected bytes and
// done events; a negedge monitor pops and compares whatever the DUT presents.
module tb_ihex_record_parser;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_rx_stb = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_byte_ready = 1'b1;
  logic        o_byte_valid;
  logic [31:0] o_byte_addr;
  logic [7:0]  o_byte_data;
  logic        o_done_stb;
  logic        o_done_err;
  logic        o_eof;
  logic        o_busy;

  int total = 0;
  int bad = 0;

  logic [39:0] byte_q [$];
  logic [1:0]  done_q [$];

  always #5 i_clk = ~i_clk;

  ihex_record_parser #(.MAX_LEN(16)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_rx_stb     (i_rx_stb),
    .i_rx_data    (i_rx_data),
    .o_byte_valid (o_byte_valid),
    .o_byte_addr  (o_byte_addr),
    .o_byte_data  (o_byte_data),
    .i_byte_ready (i_byte_ready),
    .o_done_stb   (o_done_stb),
    .o_done_err   (o_done_err),
    .o_eof        (o_eof),
    .o_busy       (o_busy)
  );

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [39:0] got);
    total++;
    bad++;
    $display("FAIL %s: got=%h expected=none", name, got);
  endtask

  // Monitor: transfers, done/eof pulses and output stability under backpressure.
  logic        stall_q = 1'b0;
  logic [39:0] held = '0;
  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && o_byte_valid) chk("hold", {o_byte_addr, o_byte_data}, held);
      if (o_byte_valid && i_byte_ready) begin
        if (byte_q.size() == 0) fail_evt("unexpected_byte", {o_byte_addr, o_byte_data});
        else chk("byte", {o_byte_addr, o_byte_data}, byte_q.pop_front());
      end
      stall_q = o_byte_valid && !i_byte_ready;
      held    = {o_byte_addr, o_byte_data};
      if (o_done_stb) begin
        if (done_q.size() == 0) fail_evt("unexpected_done", {38'd0, o_done_err, o_eof});
        else chk("done_err_eof", {38'd0, o_done_err, o_eof}, {38'd0, done_q.pop_front()});
      end else if (o_eof || o_done_err) begin
        fail_evt("stray_eof_err", {38'd0, o_done_err, o_eof});
      end
    end
  end

  task automatic exp_byte(input logic [31:0] a, input logic [7:0] d);
    byte_q.push_back({a, d});
  endtask

  task automatic exp_done(input logic err, input logic eof);
    done_q.push_back({err, eof});
  endtask

  // Expected output of the 3-byte data record 0300300002337A.
  task automatic exp_rec3(input logic [15:0] ela);
    exp_byte({ela, 16'h0030}, 8'h02);
    exp_byte({ela, 16'h0031}, 8'h33);
    exp_byte({ela, 16'h0032}, 8'h7A);
    exp_done(1'b0, 1'b0);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge i_clk); #1;
      i_rx_stb  = 1'b1;
      i_rx_data = s[i];
    end
    @(posedge i_clk); #1;
    i_rx_stb = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    total++;
    if (o_busy) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b expected=0", name, o_busy);
    end
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!o_byte_valid && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    total++;
    if (!o_byte_valid) begin
      bad++;
      $display("FAIL %s_timeout: valid=%b expected=1", name, o_byte_valid);
    end
  endtask

  initial begin
    #12;
    chk("reset_flags", {35'd0, o_byte_valid, o_done_stb, o_done_err, o_eof, o_busy}, '0);
    chk("reset_addr", {8'd0, o_byte_addr}, '0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    chk("post_reset_flags", {35'd0, o_byte_valid, o_done_stb, o_done_err, o_eof, o_busy}, '0);

    // Basic data record, ready tied high.
    exp_rec3(16'h0000);
    send(":0300300002337A1E");
    wait_idle("data1");

    // EOF record, then a record whose low address wraps.
    exp_done(1'b0, 1'b1);
    send(":00000001FF");
    wait_idle("eof");
    exp_byte(32'h0000FFFF, 8'h01);
    exp_byte(32'h00000000, 8'h02);
    exp_done(1'b0, 1'b0);
    send(":02FFFF000102FD");
    wait_idle("wrap");

    // Backpressure: ready low 5 cycles, then toggling; lower-case hex.
    i_byte_ready = 1'b0;
    exp_rec3(16'h0000);
    send(":0300300002337a1e");
    wait_valid("bp");
    repeat (5) begin
      @(posedge i_clk); #1;
    end
    for (int n = 0; n < 100 && o_busy; n++) begin
      i_byte_ready = ~i_byte_ready;
      @(posedge i_clk); #1;
    end
    i_byte_ready = 1'b1;
    wait_idle("bp");

    // Oversize length rejected after the second length character.
    exp_done(1'b1, 1'b0);
    send(":110000");
    wait_idle("len17");

    // Non-hex character in ADDR.
    exp_done(1'b1, 1'b0);
    send(":03G0300");
    wait_idle("nonhex");

    // Colon mid-ADDR aborts, the new record then parses normally.
    exp_done(1'b1, 1'b0);
    exp_rec3(16'h0000);
    send(":0300:0300300002337A1E");
    wait_idle("abort");

    // Unknown record type with a valid checksum.
    exp_done(1'b1, 1'b0);
    send(":00000006FA");
    wait_idle("type6");

    // ELA record, then data lands in the upper segment.
    exp_done(1'b0, 1'b0);
    send(":020000040800F2");
    wait_idle("ela");
    exp_rec3(16'h0800);
    send(":0300300002337A1E");
    wait_idle("data_ela");

    // Bad checksum: rejected, ELA untouched.
    exp_done(1'b1, 1'b0);
    send(":0300300002337A1F");
    wait_idle("badsum");
    exp_rec3(16'h0800);
    send(":0300300002337A1E");
    wait_idle("data_ela2");

    // Reset mid-drain drops valid at once and clears ELA.
    i_byte_ready = 1'b0;
    send(":0300300002337A1E");
    wait_valid("rst_drain");
    @(posedge i_clk); #3;
    i_reset_n = 1'b0;
    #1;
    chk("rst_drop", {38'd0, o_byte_valid, o_busy}, '0);
    @(posedge i_clk); #1;
    i_reset_n    = 1'b1;
    i_byte_ready = 1'b1;
    exp_rec3(16'h0000);
    send(":0300300002337A1E");
    wait_idle("data_after_rst");

    repeat (5) @(posedge i_clk);
    #1;
    chk("byte_q_left", 40'(byte_q.size()), '0);
    chk("done_q_left", 40'(done_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
